// File: rtl/skolem_inv_sweep_checker.sv
// Sweeps every t through a Skolem-function block and checks (-x mod 2^W) >=u t for each answer x.
// Optional macro SKC_STOP_ON_FAIL_EN: stop issuing vectors after the first failing check.
module skolem_inv_sweep_checker #(
    parameter int W   = 4,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [W-1:0] stim_o,
    input  logic [W-1:0] resp_i,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [W:0]   fail_cnt,
    output logic [W-1:0] first_fail_t,
    output logic [W-1:0] first_fail_x
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, REPORT} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         pass_q, pass_d;
    logic [W:0]   fcnt_q, fcnt_d;
    logic [W-1:0] fft_q, fft_d;
    logic [W-1:0] ffx_q, ffx_d;

    logic         issue;
    logic         chk_vld;
    logic [W-1:0] chk_t;
    logic         line_empty;
    logic [W-1:0] neg;
    logic         chk_fail;

    assign issue = (state_q == SWEEP);

    // Delay line aligns each issued t with the answer the Skolem block returns LAT cycles later.
    generate
        if (LAT == 0) begin : g_comb
            assign chk_vld    = issue;
            assign chk_t      = cnt_q;
            assign line_empty = 1'b1;
        end else begin : g_line
            logic [LAT-1:0] vld_q;
            logic [W-1:0]   t_q [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= issue;
                    for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
                end
            end

            // NOTE: payload stages carry no reset; the valid bits alone qualify them.
            always_ff @(posedge clk) begin
                t_q[0] <= cnt_q;
                for (int i = 1; i < LAT; i++) t_q[i] <= t_q[i-1];
            end

            assign chk_vld    = vld_q[LAT-1];
            assign chk_t      = t_q[LAT-1];
            assign line_empty = ~|vld_q;
        end
    endgenerate

    // x = 0 wraps to neg = 0; any X on resp_i is masked by chk_vld.
    assign neg      = ~resp_i + W'(1);
    assign chk_fail = chk_vld && (neg < chk_t);

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        fcnt_d  = fcnt_q;
        fft_d   = fft_q;
        ffx_d   = ffx_q;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    fcnt_d  = '0;
                    fft_d   = '0;
                    ffx_d   = '0;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (cnt_q == '1) state_d = DRAIN;
                else             cnt_d   = cnt_q + W'(1);
`ifdef SKC_STOP_ON_FAIL_EN
                if (chk_fail) begin
                    cnt_d   = cnt_q;
                    state_d = DRAIN;
                end
`else
`endif
            end
            DRAIN: begin
                if (line_empty) begin
                    pass_d  = (fcnt_q == '0);
                    state_d = REPORT;
                end
            end
            REPORT: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (chk_fail) begin
            fcnt_d = fcnt_q + (W+1)'(1);
            if (fcnt_q == '0) begin
                fft_d = chk_t;
                ffx_d = resp_i;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            fcnt_q  <= '0;
            fft_q   <= '0;
            ffx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            fcnt_q  <= fcnt_d;
            fft_q   <= fft_d;
            ffx_q   <= ffx_d;
        end
    end

    assign stim_o       = cnt_q;
    assign busy         = (state_q == SWEEP) || (state_q == DRAIN);
    assign pass         = pass_q;
    assign fail_cnt     = fcnt_q;
    assign first_fail_t = fft_q;
    assign first_fail_x = ffx_q;

endmodule

// File: tb/tb_skolem_inv_sweep_checker.sv
// Directed bench: combinational (LAT=0) and 2-stage registered (LAT=2) Skolem models, correct and faulty.
module tb_skolem_inv_sweep_checker;

    localparam int W = 4;
`ifdef SKC_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start0 = 1'b0, start2 = 1'b0;
    logic [W-1:0] stim0, stim2, resp0, resp2, p1, p2;
    logic         busy0, busy2, done0, done2, pass0, pass2;
    logic [W:0]   fc0, fc2;
    logic [W-1:0] ft0, ft2, fx0, fx2;

    int mode0 = 0, mode2 = 0, sel = 0;
    int checks = 0, failures = 0;

    // mode 0: x=1 (correct), 1: x=0 (fails t=1..15), 2: x=t (fails t=9..15)
    function automatic logic [W-1:0] model(input int mode, input logic [W-1:0] t);
        case (mode)
            0:       return W'(1);
            1:       return '0;
            default: return t;
        endcase
    endfunction

    assign resp0 = busy0 ? model(mode0, stim0) : 'x;
    always @(posedge clk) begin
        p1 <= busy2 ? model(mode2, stim2) : 'x;
        p2 <= p1;
    end
    assign resp2 = p2;

    skolem_inv_sweep_checker #(.W(W), .LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .stim_o(stim0), .resp_i(resp0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_cnt(fc0),
        .first_fail_t(ft0), .first_fail_x(fx0)
    );

    skolem_inv_sweep_checker #(.W(W), .LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stim_o(stim2), .resp_i(resp2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_cnt(fc2),
        .first_fail_t(ft2), .first_fail_x(fx2)
    );

    logic         busy_s, done_s, pass_s;
    logic [W-1:0] stim_s, ft_s, fx_s;
    logic [W:0]   fc_s;
    assign busy_s = (sel != 0) ? busy2 : busy0;
    assign done_s = (sel != 0) ? done2 : done0;
    assign pass_s = (sel != 0) ? pass2 : pass0;
    assign stim_s = (sel != 0) ? stim2 : stim0;
    assign ft_s   = (sel != 0) ? ft2   : ft0;
    assign fx_s   = (sel != 0) ? fx2   : fx0;
    assign fc_s   = (sel != 0) ? fc2   : fc0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic b);
        if (sel != 0) start2 = b;
        else          start0 = b;
    endtask

    // Pulse start (cycle 0), optionally pulse again in cycle restart_at, then check the report.
    task automatic run(input string tag, input int restart_at, input int exp_cyc,
                       input logic exp_pass, input int exp_fc, input int exp_ft, input int exp_fx);
        int cyc;
        cyc = -1;
        @(negedge clk); set_start(1'b1);
        @(negedge clk); set_start(1'b0);
        check({tag, " busy_c1"}, 32'(busy_s), 32'd1);
        check({tag, " stim_c1"}, 32'(stim_s), 32'd0);
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) @(negedge clk);
            set_start(c == restart_at);
            if (done_s) begin
                cyc = c;
                break;
            end
        end
        check({tag, " done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " busy_at_done"}, 32'(busy_s), 32'd0);
        check({tag, " pass"}, 32'(pass_s), 32'(exp_pass));
        check({tag, " fail_cnt"}, 32'(fc_s), 32'(exp_fc));
        check({tag, " first_t"}, 32'(ft_s), 32'(exp_ft));
        check({tag, " first_x"}, 32'(fx_s), 32'(exp_fx));
        @(negedge clk); set_start(1'b0);
        check({tag, " idle_busy"}, 32'(busy_s), 32'd0);
        check({tag, " idle_done"}, 32'(done_s), 32'd0);
    endtask

    initial begin
        bit seen_done;

        repeat (2) @(negedge clk);
        check("rst stim0", 32'(stim0), 32'd0);
        check("rst busy0", 32'(busy0), 32'd0);
        check("rst done0", 32'(done0), 32'd0);
        check("rst pass0", 32'(pass0), 32'd0);
        check("rst fc0", 32'(fc0), 32'd0);
        check("rst ft0", 32'(ft0), 32'd0);
        check("rst fx0", 32'(fx0), 32'd0);
        check("rst busy2", 32'(busy2), 32'd0);
        check("rst fc2", 32'(fc2), 32'd0);
        rst_n = 1'b1;

        sel = 0;
        mode0 = 0;
        run("l0_good", 0, 18, 1'b1, 0, 0, 0);
        mode0 = 1;
        run("l0_x0", 0, STOP ? 4 : 18, 1'b0, STOP ? 1 : 15, 1, 0);
        mode0 = 2;
        run("l0_xt", 0, STOP ? 12 : 18, 1'b0, STOP ? 1 : 7, 9, 9);
        mode0 = 0;
        run("l0_restart5", 5, 18, 1'b1, 0, 0, 0);
        run("l0_start_in_report", 18, 18, 1'b1, 0, 0, 0);

        // Abort a sweep with reset in cycle 9.
        mode0 = 1;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (8) @(negedge clk);
        check("abort busy_before", 32'(busy0), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort stim", 32'(stim0), 32'd0);
        check("abort busy", 32'(busy0), 32'd0);
        check("abort done", 32'(done0), 32'd0);
        check("abort pass", 32'(pass0), 32'd0);
        check("abort fc", 32'(fc0), 32'd0);
        check("abort ft", 32'(ft0), 32'd0);
        check("abort fx", 32'(fx0), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done0) seen_done = 1'b1;
        end
        check("abort no_done", 32'(seen_done), 32'd0);
        check("abort idle_busy", 32'(busy0), 32'd0);
        mode0 = 0;
        run("l0_after_abort", 0, 18, 1'b1, 0, 0, 0);

        sel = 1;
        mode2 = 0;
        run("l2_good", 0, 20, 1'b1, 0, 0, 0);
        mode2 = 1;
        run("l2_x0", 0, STOP ? 8 : 20, 1'b0, STOP ? 3 : 15, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/skolem_inv_sweep_checker.md
Name: skolem_inv_sweep_checker

Overview:
- Sequential verification stage placed directly downstream of a generated Skolem-function netlist. The first target is the 4-bit bvuge/bvneg invertibility solver.
- Drives every t value into the Skolem block (stim_o) and consumes its x answer (resp_i).
- Checks the invertibility constraint (-x mod 2^W) >=u t for each vector.
- Reports pass/fail, the failure count and the first counterexample, so each exported Skolem netlist is signed off in simulation or on an FPGA.

Parameters:
- W, 4, bit width of t and x. Sweep length is 2^W vectors.
- LAT, 0, number of register stages between stim_o and a valid resp_i. 0 means the Skolem block is purely combinational.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE
- stim_o  out  W  t vector driven to the Skolem block inputs
- resp_i  in  W  x answer from the Skolem block outputs
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the sweep result is final
- pass  out  1  result of the last completed sweep; 1 = zero failures
- fail_cnt  out  W+1  number of failing vectors in the current/last sweep
- first_fail_t  out  W  t of the first failing vector
- first_fail_x  out  W  x returned for the first failing vector

Behaviour:
- Reset (async, rst_n=0): state=IDLE, stim_o=0, busy=0, done=0, pass=0, fail_cnt=0, first_fail_t=0, first_fail_x=0, delay line valid bits cleared.
- Reset asserted mid-sweep aborts the sweep immediately. No done pulse is produced and pass stays 0.
- States: IDLE, SWEEP, DRAIN, REPORT.
- IDLE:
  - start=1: clear fail_cnt, first_fail_*, pass; stim counter=0; go SWEEP.
  - Otherwise hold all outputs.
- SWEEP: stim_o = counter. One vector issued per cycle, cycles 1..2^W after start is accepted. The issued t and a valid bit enter a LAT-deep delay line. After t=2^W-1 is issued, go DRAIN. The counter must not wrap to 0 and issue again.
- DRAIN: no new vectors. Stay until the delay line holds no valid entries. With LAT=0 DRAIN lasts exactly 1 cycle. Then go REPORT.
- REPORT:
  - done=1 for exactly 1 cycle.
  - pass = (fail_cnt==0).
  - busy drops in the same cycle.
  - Next state IDLE.
- Check:
  - Performed in every cycle where the delayed valid bit is 1, pairing the delayed t with the current resp_i.
  - neg = (~resp_i + 1) truncated to W bits, so x=0 gives neg=0.
  - ok = (neg >= t) unsigned.
  - If !ok: fail_cnt += 1. If fail_cnt was 0, also capture first_fail_t and first_fail_x.
  - fail_cnt is W+1 bits, so 2^W failures fit without overflow and no saturation is needed.
- Timing (start accepted at cycle 0): stim t=k appears in cycle k+1 and is checked in cycle k+1+LAT. done is high in cycle 2^W+LAT+2.
- start while busy is ignored, with no restart and no effect on counters.
- start coincident with the REPORT cycle is ignored. A new sweep needs start in IDLE.
- resp_i is ignored whenever the delayed valid bit is 0, including X values.

Optional Feature:
- Macro SKC_STOP_ON_FAIL_EN.
- Defined: on the first failing check, SWEEP stops issuing new vectors and goes to DRAIN. Checks on in-flight vectors still count, so fail_cnt may exceed 1 when LAT>0. REPORT then follows as normal, with pass=0.
- Undefined: the full 2^W sweep always runs, and fail_cnt is the total number of failures.

Test Plan:
- Correct model (x=1 for every t, so neg=15), W=4, LAT=0, pulse start -> done in cycle 18, pass=1, fail_cnt=0, first_fail_t=0, first_fail_x=0.
- Faulty model (x=0 always, so neg=0), LAT=0 -> t=1..15 fail; fail_cnt=15, first_fail_t=1, first_fail_x=0, pass=0.
- LAT=2 with a 2-stage registered copy of the correct model -> done in cycle 20, pass=1. Same LAT with the x=0 fault -> fail_cnt=15, first_fail_t=1.
- Second start pulse at cycle 5 during a sweep -> ignored; done still in cycle 18 with identical results. A start pulse after done returns to IDLE -> fresh sweep, counters cleared.
- rst_n low at cycle 9 of a sweep -> all outputs 0 immediately; no done pulse. A later start runs a complete sweep with correct results.
- SKC_STOP_ON_FAIL_EN, LAT=0, x=0 model -> stimulus stops after t=1; fail_cnt=1, first_fail_t=1, pass=0, done in cycle 4.
